hififo_loopback_multi: RTL

Parametrised multi-channel traffic block attached to the hififo_pcie FIFO ports; successor to the single-channel FPGA loopback top. Each channel independently loops from-PC (fpc) data back to the to-PC (tpc) FIFO, generates an incrementing test pattern, checks an incrementing pattern, or drains. It provides per-channel word and error counters for software self-test, and drives the board LEDs from channel 0 traffic.

---
 rtl/hififo_loopback_multi.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/hififo_loopback_multi.sv
// hififo_loopback_multi
//   Multi-channel traffic block for the hififo_pcie FIFO ports. Each channel
//   runs one of four modes selected by its 2-bit mode slice:
//     0 loopback : from-PC words are written back to the to-PC FIFO
//     1 generate : writes an incrementing pattern starting at 0
//     2 check    : consumes words and counts breaks in an incrementing pattern
//     3 drain    : consumes and counts words without checking
//   Per-channel word and error counters support software self-test.
//   The board LEDs show the low nibble of the last word consumed on channel 0.
//
// Ports (channel n occupies slice n of every flattened bus)
//   clock       single clock for all logic and the FIFO interfaces
//   rst_n       asynchronous active-low reset
//   mode        2 bits per channel, mode select
//   clear       synchronous clear of counters and pattern state
//   fpc_data    from-PC FIFO head word (first-word-fall-through)
//   fpc_valid   fpc_data holds a valid word
//   fpc_read    consume request; a word moves when fpc_valid && fpc_read
//   tpc_data    to-PC FIFO write data
//   tpc_write   to-PC FIFO write strobe
//   tpc_ready   to-PC FIFO has room for at least 4 more words
//   word_count  32 bits per channel, words consumed or written, wraps
//   err_count   32 bits per channel, checker mismatches, saturating
//   led         low nibble of the last word consumed on channel 0
module hififo_loopback_multi #(
  parameter int CHANNELS = 1,
  parameter int WIDTH    = 64
) (
  input  logic                      clock,
  input  logic                      rst_n,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic                      clear,
  input  logic [WIDTH*CHANNELS-1:0] fpc_data,
  input  logic [CHANNELS-1:0]       fpc_valid,
  output logic [CHANNELS-1:0]       fpc_read,
  output logic [WIDTH*CHANNELS-1:0] tpc_data,
  output logic [CHANNELS-1:0]       tpc_write,
  input  logic [CHANNELS-1:0]       tpc_ready,
  output logic [32*CHANNELS-1:0]    word_count,
  output logic [32*CHANNELS-1:0]    err_count,
  output logic [3:0]                led
);

  localparam logic [1:0] MODE_LOOP  = 2'd0;
  localparam logic [1:0] MODE_GEN   = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Registered state. mode_p0 is the mode in force since the last edge: it
  // governs what the current fpc_read/tpc_write values mean, so a consume in
  // this cycle is handled by the mode that requested it.
  logic [CHANNELS-1:0][1:0]       mode_p0;
  logic [CHANNELS-1:0]            rd_p0, wr_p0, gen_wr_p0;
  logic [CHANNELS-1:0][WIDTH-1:0] data_p0, gen_p0, exp_p0;
  logic [CHANNELS-1:0][31:0]      wc_p0, err_p0;
  logic [3:0]                     led_p0;

  logic [CHANNELS-1:0]            cons, lb, gen_go;
  logic [CHANNELS-1:0]            rd_n, wr_n, gen_wr_n;
  logic [CHANNELS-1:0][WIDTH-1:0] data_n, gen_n, exp_n;
  logic [CHANNELS-1:0][31:0]      wc_n, err_n;
  logic [3:0]                     led_n;

  always_comb begin
    cons     = '0;
    lb       = '0;
    gen_go   = '0;
    rd_n     = '0;
    wr_n     = '0;
    gen_wr_n = '0;
    data_n   = data_p0;
    gen_n    = gen_p0;
    exp_n    = exp_p0;
    wc_n     = wc_p0;
    err_n    = err_p0;
    led_n    = led_p0;
    for (int c = 0; c < CHANNELS; c++) begin
      cons[c] = fpc_valid[c] & rd_p0[c];
      // A word consumed under loopback is written next cycle even if the mode
      // input has already moved on; it takes priority over a generator write.
      lb[c]     = cons[c] && (mode_p0[c] == MODE_LOOP);
      gen_go[c] = !lb[c] && (mode[2*c +: 2] == MODE_GEN) && tpc_ready[c];

      if ((mode[2*c +: 2] == MODE_GEN) && (mode_p0[c] != MODE_GEN))
        gen_n[c] = '0;
      if ((mode[2*c +: 2] == MODE_CHECK) && (mode_p0[c] != MODE_CHECK))
        exp_n[c] = '0;

      if (mode[2*c +: 2] == MODE_LOOP) rd_n[c] = tpc_ready[c];
      else                             rd_n[c] = (mode[2*c +: 2] != MODE_GEN);

      wr_n[c]     = lb[c] | gen_go[c];
      gen_wr_n[c] = gen_go[c];
      if (lb[c]) begin
        data_n[c] = fpc_data[WIDTH*c +: WIDTH];
      end else if (gen_go[c]) begin
        data_n[c] = gen_n[c];
        gen_n[c]  = gen_n[c] + WIDTH'(1);
      end

      if (cons[c] && (mode_p0[c] == MODE_CHECK)) begin
        if (fpc_data[WIDTH*c +: WIDTH] == exp_p0[c]) begin
          exp_n[c] = exp_p0[c] + WIDTH'(1);
        end else begin
          err_n[c] = sat_inc(err_p0[c]);
          exp_n[c] = fpc_data[WIDTH*c +: WIDTH] + WIDTH'(1);
        end
      end

      // Generator writes are counted once they are on the bus.
      if (cons[c] || (wr_p0[c] && gen_wr_p0[c]))
        wc_n[c] = wc_p0[c] + 32'd1;

      if (clear) begin
        wc_n[c]  = '0;
        err_n[c] = '0;
        gen_n[c] = '0;
        exp_n[c] = '0;
      end
    end
    if (cons[0]) led_n = fpc_data[3:0];
  end

  // ---- stage p0: handshake, data and counter registers ----
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      mode_p0   <= '0;
      rd_p0     <= '0;
      wr_p0     <= '0;
      gen_wr_p0 <= '0;
      data_p0   <= '0;
      gen_p0    <= '0;
      exp_p0    <= '0;
      wc_p0     <= '0;
      err_p0    <= '0;
      led_p0    <= 4'h5;
    end else begin
      mode_p0   <= mode;
      rd_p0     <= rd_n;
      wr_p0     <= wr_n;
      gen_wr_p0 <= gen_wr_n;
      data_p0   <= data_n;
      gen_p0    <= gen_n;
      exp_p0    <= exp_n;
      wc_p0     <= wc_n;
      err_p0    <= err_n;
      led_p0    <= led_n;
    end
  end

  assign fpc_read   = rd_p0;
  assign tpc_write  = wr_p0;
  assign tpc_data   = data_p0;
  assign word_count = wc_p0;
  assign err_count  = err_p0;
  assign led        = led_p0;

endmodule
